// File: rtl/ax_branch_target_buffer.sv
// rtl/ax_branch_target_buffer.sv - approximate direct-mapped branch target buffer
//
// Purpose: indexed by the NextPC-stage PC, returns one registered hit/target
// pair per fetch lane in the IF stage. Entries are installed through a small
// update FIFO that drains one entry per cycle. Valid bits are cleared by an
// initialization sweep after reset and on flush.
//
// Ports:
//   i_clk          clock
//   i_rst          asynchronous active-low reset
//   i_lookupPC     NextPC-stage fetch PC; lane i looks up PC + 4*i
//   i_stall        holds the IF-stage output registers
//   o_axbtbHit     per-lane hit (IF stage)
//   o_axbtbTarget  per-lane target, lane i at [i*PC_WIDTH +: PC_WIDTH]
//   i_updValid     install request
//   i_updPC        branch PC to install
//   i_updTarget    branch target to install
//   o_updReady     update FIFO can accept a request
//   i_flushReq     invalidate all entries (restarts the sweep)
//   o_initBusy     initialization sweep in progress
module ax_branch_target_buffer #(
  parameter int FETCH_WIDTH     = 2,
  parameter int ENTRY_NUM       = 256,
  parameter int TAG_WIDTH       = 8,
  parameter int PC_WIDTH        = 32,
  parameter int UPD_QUEUE_DEPTH = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [PC_WIDTH-1:0]             i_lookupPC,
  input  logic                            i_stall,
  output logic [FETCH_WIDTH-1:0]          o_axbtbHit,
  output logic [FETCH_WIDTH*PC_WIDTH-1:0] o_axbtbTarget,
  input  logic                            i_updValid,
  input  logic [PC_WIDTH-1:0]             i_updPC,
  input  logic [PC_WIDTH-1:0]             i_updTarget,
  output logic                            o_updReady,
  input  logic                            i_flushReq,
  output logic                            o_initBusy
);

  localparam int IDX  = $clog2(ENTRY_NUM);
  localparam int KEYW = IDX + TAG_WIDTH;
  localparam int QPW  = (UPD_QUEUE_DEPTH > 1) ? $clog2(UPD_QUEUE_DEPTH) : 1;
  localparam int QCW  = $clog2(UPD_QUEUE_DEPTH + 1);

  typedef enum logic {ST_INIT, ST_NORMAL} state_t;

  state_t                r_state;
  logic [IDX-1:0]        r_cnt;
  logic                  r_init_busy;
  logic [QPW-1:0]        r_wr_ptr;
  logic [QPW-1:0]        r_rd_ptr;
  logic [QCW-1:0]        r_count;

  // Entry storage: no reset; the sweep is the only thing that clears valid.
  logic                  r_valid  [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  r_tag    [ENTRY_NUM];
  logic [PC_WIDTH-1:0]   r_target [ENTRY_NUM];

  // Update FIFO holds {tag, index} rather than the full PC.
  logic [KEYW-1:0]       r_q_key  [UPD_QUEUE_DEPTH];
  logic [PC_WIDTH-1:0]   r_q_tgt  [UPD_QUEUE_DEPTH];

  logic [FETCH_WIDTH-1:0]          r_hit;
  logic [FETCH_WIDTH*PC_WIDTH-1:0] r_tgt;

  logic                            w_sweep_last;
  logic                            w_lookup_en;
  logic                            w_enq;
  logic                            w_deq;
  logic [IDX-1:0]                  w_base_idx;
  logic [KEYW-1:0]                 w_head_key;
  logic [FETCH_WIDTH-1:0]          w_lane_hit;
  logic [FETCH_WIDTH*PC_WIDTH-1:0] w_lane_tgt;
  logic                            w_unused_upd;

  assign w_sweep_last = (r_state == ST_INIT) && (r_cnt == IDX'(ENTRY_NUM - 1)) && !i_flushReq;
  // The edge that leaves INIT already carries a real lookup.
  assign w_lookup_en  = (r_state == ST_NORMAL) || w_sweep_last;
  assign o_updReady   = (r_state == ST_NORMAL) && (r_count != QCW'(UPD_QUEUE_DEPTH));
  // Flush wins over both the incoming request and the queued head.
  assign w_enq        = i_updValid && o_updReady && !i_flushReq;
  assign w_deq        = (r_state == ST_NORMAL) && (r_count != '0) && !i_flushReq;
  assign w_base_idx   = i_lookupPC[IDX+1:2];
  assign w_head_key   = r_q_key[r_rd_ptr];
  assign w_unused_upd = ^{i_updPC[1:0], i_updPC[PC_WIDTH-1:IDX+TAG_WIDTH+2]};

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    logic [PC_WIDTH-1:0]  w_pc;
    logic [IDX-1:0]       w_idx;
    logic [TAG_WIDTH-1:0] w_tag;
    logic                 w_unused_pc;
    assign w_pc        = i_lookupPC + PC_WIDTH'(4 * g);
    // Index wraps modulo ENTRY_NUM; the tag comes from the true lane PC.
    assign w_idx       = w_base_idx + IDX'(g);
    assign w_tag       = w_pc[IDX+TAG_WIDTH+1:IDX+2];
    assign w_unused_pc = ^{w_pc[1:0], w_pc[PC_WIDTH-1:IDX+TAG_WIDTH+2]};
    // On the last sweep edge the entry under the counter is still being
    // cleared, so its stale valid bit is masked.
    assign w_lane_hit[g] = w_lookup_en && r_valid[w_idx] && (r_tag[w_idx] == w_tag)
                           && !((r_state == ST_INIT) && (w_idx == r_cnt));
    assign w_lane_tgt[g*PC_WIDTH +: PC_WIDTH] = r_target[w_idx];
  end

  // Control FSM and update FIFO pointers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_busy <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (i_flushReq) begin
            r_cnt <= '0;
          end else if (r_cnt == IDX'(ENTRY_NUM - 1)) begin
            r_cnt       <= '0;
            r_state     <= ST_NORMAL;
            r_init_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + IDX'(1);
          end
        end
        default: begin
          if (i_flushReq) begin
            r_state     <= ST_INIT;
            r_init_busy <= 1'b1;
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
          end else begin
            if (w_enq)
              r_wr_ptr <= (r_wr_ptr == QPW'(UPD_QUEUE_DEPTH - 1)) ? '0 : r_wr_ptr + QPW'(1);
            if (w_deq)
              r_rd_ptr <= (r_rd_ptr == QPW'(UPD_QUEUE_DEPTH - 1)) ? '0 : r_rd_ptr + QPW'(1);
            if (w_enq && !w_deq)
              r_count <= r_count + QCW'(1);
            else if (w_deq && !w_enq)
              r_count <= r_count - QCW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_q_key[r_wr_ptr] <= i_updPC[IDX+TAG_WIDTH+1:2];
      r_q_tgt[r_wr_ptr] <= i_updTarget;
    end
  end

  // Sweep clears and drains share the array write port; they never overlap
  // because draining only happens in NORMAL.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_INIT) begin
      r_valid[r_cnt] <= 1'b0;
    end else if (w_deq) begin
      r_valid[w_head_key[IDX-1:0]]  <= 1'b1;
      r_tag[w_head_key[IDX-1:0]]    <= w_head_key[KEYW-1:IDX];
      r_target[w_head_key[IDX-1:0]] <= r_q_tgt[r_rd_ptr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hit <= '0;
      r_tgt <= '0;
    end else if (!i_stall) begin
      r_hit <= w_lane_hit;
      r_tgt <= w_lane_tgt;
    end
  end

  assign o_axbtbHit    = r_hit;
  assign o_axbtbTarget = r_tgt;
  assign o_initBusy    = r_init_busy;

endmodule

// File: tb/tb_ax_branch_target_buffer.sv
// tb/tb_ax_branch_target_buffer.sv - scoreboard bench for ax_branch_target_buffer
module tb_ax_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        stall;
  logic [1:0]  hit;
  logic [63:0] tgt;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_tgt;
  logic        upd_ready;
  logic        flush;
  logic        init_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [1:0]  hit;
    logic [1:0]  tmask;
    logic [31:0] t0;
    logic [31:0] t1;
  } exp_t;

  exp_t sb[$];
  logic lk_issue    = 1'b0;
  logic mon_pending = 1'b0;

  always #5 clk = ~clk;

  ax_branch_target_buffer dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_lookupPC    (lookup_pc),
    .i_stall       (stall),
    .o_axbtbHit    (hit),
    .o_axbtbTarget (tgt),
    .i_updValid    (upd_valid),
    .i_updPC       (upd_pc),
    .i_updTarget   (upd_tgt),
    .o_updReady    (upd_ready),
    .i_flushReq    (flush),
    .o_initBusy    (init_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A lookup marked at an edge has its expected result in the scoreboard;
  // the monitor compares it on the following falling edge.
  always @(posedge clk) mon_pending <= lk_issue;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_pending) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got output with no expected entry");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hit"}, hit, e.hit);
          if (e.tmask[0]) chk({e.name, "_t0"}, tgt[31:0], e.t0);
          if (e.tmask[1]) chk({e.name, "_t1"}, tgt[63:32], e.t1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic [1:0] ehit,
                        input logic [1:0] tmask, input logic [31:0] t0, input logic [31:0] t1);
    exp_t e;
    e.name = name; e.hit = ehit; e.tmask = tmask; e.t0 = t0; e.t1 = t1;
    lookup_pc = pc;
    lk_issue  = 1'b1;
    sb.push_back(e);
    tick();
    lk_issue  = 1'b0;
  endtask

  task automatic install(input logic [31:0] pc, input logic [31:0] t);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_tgt   = t;
    chk("install_ready", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    tick();
  endtask

  // Expects the sweep to be active now and to end exactly 256 edges later.
  task automatic sweep_check(input int n_upd);
    chk("init_busy_start", init_busy, 1);
    for (int i = 0; i < 255; i++) begin
      if (i < n_upd) begin
        upd_valid = 1'b1;
        upd_pc    = 32'h3000 + 32'(4 * i);
        upd_tgt   = 32'hC000 + 32'(i);
        chk("sweep_ready", upd_ready, 0);
      end else begin
        upd_valid = 1'b0;
      end
      tick();
      chk("init_busy", init_busy, 1);
      chk("init_hit", hit, 0);
    end
    upd_valid = 1'b0;
    tick();
    chk("init_done", init_busy, 0);
    chk("ready_after_init", upd_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; lookup_pc = 32'h100; stall = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_tgt = '0; flush = 1'b0;
    repeat (3) tick();
    chk("rst_hit", hit, 0);
    chk("rst_tgt", tgt, 0);
    chk("rst_busy", init_busy, 1);
    chk("rst_ready", upd_ready, 0);
    rst_n = 1'b1;
    sweep_check(0);

    install(32'h100, 32'h2000);
    lookup("hit_lane0", 32'h100, 2'b01, 2'b01, 32'h2000, 0);
    lookup("hit_lane1", 32'h0FC, 2'b10, 2'b10, 0, 32'h2000);
    lookup("tag_miss",  32'h500, 2'b00, 2'b00, 0, 0);

    install(32'h000, 32'h3000);
    lookup("wrap_miss", 32'h3FC, 2'b00, 2'b00, 0, 0);
    install(32'h400, 32'h4000);
    lookup("wrap_hit",  32'h3FC, 2'b10, 2'b10, 0, 32'h4000);

    // Lookup sampled on the drain edge of the same index sees the old entry.
    upd_valid = 1'b1; upd_pc = 32'h800; upd_tgt = 32'h5000;
    chk("same_ready", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    lookup("old_entry", 32'h3FC, 2'b10, 2'b10, 0, 32'h4000);
    lookup("new_entry", 32'h7FC, 2'b10, 2'b10, 0, 32'h5000);

    lookup("pre_stall", 32'h100, 2'b01, 2'b01, 32'h2000, 0);
    stall = 1'b1;
    lookup("stall_hold",  32'h0FC, 2'b01, 2'b01, 32'h2000, 0);
    lookup("stall_hold2", 32'h500, 2'b01, 2'b01, 32'h2000, 0);
    install(32'h104, 32'h2104);
    chk("stall_held_hit", hit, 2'b01);
    stall = 1'b0;
    lookup("post_stall", 32'h100, 2'b11, 2'b11, 32'h2000, 32'h2104);

    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1;
      upd_pc    = 32'h1000 + 32'(4 * i);
      upd_tgt   = 32'hA000 + 32'(16 * i);
      chk("burst_ready", upd_ready, 1);
      tick();
    end
    upd_valid = 1'b0;
    tick();
    lookup("burst_01", 32'h1000, 2'b11, 2'b11, 32'hA000, 32'hA010);
    lookup("burst_23", 32'h1008, 2'b11, 2'b11, 32'hA020, 32'hA030);

    // Flush with a simultaneous request; the request is dropped.
    upd_valid = 1'b1; upd_pc = 32'h2000; upd_tgt = 32'hBEEF; flush = 1'b1;
    chk("flush_ready", upd_ready, 1);
    tick();
    upd_valid = 1'b0; flush = 1'b0;
    sweep_check(3);
    lookup("flush_0100", 32'h0100, 2'b00, 2'b00, 0, 0);
    lookup("flush_1000", 32'h1000, 2'b00, 2'b00, 0, 0);
    lookup("flush_drop", 32'h1FFC, 2'b00, 2'b00, 0, 0);
    lookup("bp_drop",    32'h3000, 2'b00, 2'b00, 0, 0);

    // Flush during the sweep restarts it from zero.
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (100) tick();
    chk("mid_sweep_busy", init_busy, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    sweep_check(0);

    // Asynchronous reset mid-drain.
    install(32'h100, 32'h2000);
    lookup("pre_reset", 32'h100, 2'b01, 2'b01, 32'h2000, 0);
    upd_valid = 1'b1; upd_pc = 32'h104; upd_tgt = 32'h2104;
    tick();
    upd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hit", hit, 0);
    chk("async_rst_tgt", tgt, 0);
    chk("async_rst_busy", init_busy, 1);
    chk("async_rst_ready", upd_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    sweep_check(0);
    lookup("post_reset", 32'h100, 2'b00, 2'b00, 0, 0);
    tick();
    chk("sb_drained", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ax_branch_target_buffer.md
# ax_branch_target_buffer

Approximate branch target buffer (AXBTB) for the fetch unit. It is indexed by the NextPC-stage PC and returns one registered hit/target pair per fetch lane in the IF stage. Those hits feed the probabilistic branch decider, which gates them into taken decisions. Entries are installed through a small buffered update port. Valid bits are cleared by an initialization sweep after reset and on flush.

## Interface
Parameters:
- FETCH_WIDTH, 2, lanes looked up per cycle; lane i uses PC + 4*i
- ENTRY_NUM, 256, entries; power of two; direct-mapped
- TAG_WIDTH, 8, tag bits stored per entry
- PC_WIDTH, 32, PC and target width
- UPD_QUEUE_DEPTH, 2, update FIFO depth

Ports:
- clk  in  1  clock; one clock
- rst  in  1  reset; asynchronous, active-low
- lookupPC  in  PC_WIDTH  NextPC-stage fetch PC
- stall  in  1  holds IF-stage outputs
- axbtbHit  out  FETCH_WIDTH  per-lane hit, IF stage
- axbtbTarget  out  FETCH_WIDTH*PC_WIDTH  per-lane target; lane i occupies bits [i*PC_WIDTH +: PC_WIDTH]
- updValid  in  1  install request
- updPC  in  PC_WIDTH  branch PC to install
- updTarget  in  PC_WIDTH  branch target
- updReady  out  1  update FIFO can accept a request
- flushReq  in  1  invalidate all entries
- initBusy  out  1  initialization sweep in progress

## Operation
Address fields and entry format:
- IDX = log2(ENTRY_NUM).
- Index = pc[IDX+1:2]; tag = pc[IDX+TAG_WIDTH+1:IDX+2].
- Lane index = index(lookupPC) + i, modulo ENTRY_NUM. Wrap-around from the last entry to entry 0 is legal.
- Entry = {valid, tag, target}. Valid bits live in non-reset storage and are cleared only by the sweep.

Lookup:
- hit_i = valid[idx_i] && tag[idx_i] == tag(lookupPC + 4*i).
- Target is taken from the entry regardless of hit.

Update FIFO:
- Enqueue when updValid && updReady.
- updReady = !full && state == NORMAL.
- Head drains into the array one entry per cycle while state == NORMAL.
- A drain sets valid, tag and target at the index, overwriting any previous entry.

States:
- INIT: sweep counter clears valid[cnt] one per cycle. Lookups report a miss and the FIFO is neither drained nor accepting.
  - When cnt == ENTRY_NUM-1, cnt wraps to 0 and the state goes to NORMAL.
  - initBusy = (state == INIT).
- NORMAL: lookup and drain.
  - flushReq goes to INIT with cnt = 0 and empties the FIFO.

## Timing
Reset values (rst low):
- state = INIT, cnt = 0.
- axbtbHit = 0, axbtbTarget = 0.
- FIFO empty, updReady = 0, initBusy = 1.

Lookup and write latency:
- lookupPC sampled at edge t produces axbtbHit and axbtbTarget valid after t, for one cycle (1-cycle latency).
- A drain written at edge t is visible to a lookup sampled at edge t+1.
- A same-index lookup and drain in the same cycle returns the old entry.

Stall:
- While stall = 1, output registers hold their values and lookupPC is ignored.
- Entries written during the stall are not reflected until the next unstalled lookup.

Initialization:
- INIT lasts exactly ENTRY_NUM cycles after reset deassertion or after flushReq.
- Outputs are registered as miss throughout INIT.
- The first real lookup is sampled on the edge where the state enters NORMAL.

Boundary conditions:
- flushReq in NORMAL with a simultaneous enqueue: flush wins. Queued and incoming requests are dropped; lost installs are acceptable for an approximate BTB.
- flushReq during INIT restarts cnt at 0.
- FIFO full: updReady = 0. Enqueue and drain in the same cycle keep the count unchanged.
- rst asserted mid-sweep or mid-drain: immediately returns to the reset values above.

## Test plan
- Reset, then idle: initBusy = 1 for 256 cycles and axbtbHit = 0 throughout. Then initBusy = 0 and updReady = 1.
- Install updPC = 0x100, updTarget = 0x2000, then look up lookupPC = 0x100:
  - axbtbHit = 2'b01 and lane 0 target = 0x2000.
  - Lookup 0x0FC gives hit = 2'b10.
- Tag mismatch: after installing 0x100, look up 0x100 + 4*256 = 0x500 (same index, different tag) -> axbtbHit = 0.
- Wrap-around: install 0x000, look up 0x3FC -> lane 1 indexes entry 0 with the wrong tag -> miss. Installing 0x400 then makes lookup 0x3FC report hit = 2'b10.
- Backpressure:
  - Three back-to-back updValid with the drain blocked by an in-progress sweep: updReady = 0 and nothing enqueues.
  - In NORMAL, four consecutive requests are all accepted, since the FIFO drains one per cycle.
- flushReq after installs: initBusy = 1 for 256 cycles, all prior installs miss, and a request enqueued on the flush cycle never hits.
